// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard unit for a five-stage pipeline (F/D/E/M/W) with a multi-cycle mul/div
// unit attached to E and a data memory in M that can back-pressure.
//
// The unit produces:
//   - operand forwarding selects for the two E-stage source operands,
//   - per-stage stall (hold) and flush (bubble) controls,
//   - a one-cycle launch pulse for the mul/div unit,
//   - saturating stall and flush performance counters.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   rs1_d, rs2_d               decode-stage source register addresses
//   rs1_e, rs2_e, rd_e         execute-stage source/destination addresses
//   rd_m, rd_w                 M/W destination addresses
//   reg_write_m, reg_write_w   M/W register write enables
//   result_src_e               E result source, bit 0 marks a load
//   pc_src_e                   branch/jump taken in E
//   md_start_e                 mul/div op present in E (held while in E)
//   md_done                    one-cycle mul/div completion pulse
//   mem_req_m, mem_ready_m     data memory request in M and its ready
//   perf_clr                   synchronous clear of both counters
//   forward_a_e, forward_b_e   operand select (FORWARD_NONE/_WB/_MEM)
//   md_go                      one-cycle mul/div launch pulse
//   stall_f/d/e/m              per-stage hold
//   flush_d/e/m/w              per-stage bubble insert
//   stall_cnt, flush_cnt       performance counters
//   md_state_o                 current mul/div FSM state (debug)
//
// Forward select encoding: FORWARD_NONE = 2'b00, FORWARD_WB = 2'b01,
//                          FORWARD_MEM  = 2'b10.
// FSM state encoding on md_state_o: IDLE = 0, MD_BUSY = 1, MD_HOLD = 2.
//
// Handshake: the mul/div unit is launched by md_go, which is a single-cycle
// pulse issued only from IDLE while md_start_e is high and the memory stage is
// not waiting. The unit answers with exactly one md_done pulse. If that pulse
// lands while the memory stage is waiting, it is remembered in MD_HOLD so the
// op is neither lost nor relaunched. A data-memory transfer completes in the
// cycle where mem_req_m and mem_ready_m are both high.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic [1:0]        result_src_e,
  input  logic              pc_src_e,
  input  logic              md_start_e,
  input  logic              md_done,
  input  logic              mem_req_m,
  input  logic              mem_ready_m,
  input  logic              perf_clr,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              md_go,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [1:0]        md_state_o
);

  localparam logic [1:0] FORWARD_NONE = 2'b00;
  localparam logic [1:0] FORWARD_WB   = 2'b01;
  localparam logic [1:0] FORWARD_MEM  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_MD_HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Only bit 0 of result_src_e (load) matters to hazard detection.
  logic unused_result_src;
  assign unused_result_src = result_src_e[1];

  // ---------------------------------------------------------------------------
  // Forwarding: the youngest producer (M) wins over W; x0 is never forwarded.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdm,
    input logic              wem,
    input logic [REG_AW-1:0] rdw,
    input logic              wew
  );
    logic [1:0] sel;
    sel = FORWARD_NONE;
    if (rs != '0) begin
      if (wem && (rs == rdm)) begin
        sel = FORWARD_MEM;
      end else if (wew && (rs == rdw)) begin
        sel = FORWARD_WB;
      end
    end
    return sel;
  endfunction

  logic [1:0] fwd_a_raw, fwd_b_raw;
  assign fwd_a_raw = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
  assign fwd_b_raw = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

  // ---------------------------------------------------------------------------
  // Hazard sources
  // ---------------------------------------------------------------------------
  logic mem_wait;
  logic lwstall;
  logic md_stall;
  logic md_launch;
  logic in_idle, in_busy;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_busy  = (state_q == ST_MD_BUSY);

  assign mem_wait = mem_req_m & ~mem_ready_m;

  // A load to x0 produces nothing a consumer could depend on.
  assign lwstall  = result_src_e[0] & (rd_e != '0) &
                    ((rs1_d == rd_e) | (rs2_d == rd_e));

  // E must hold while a mul/div op is pending launch or still computing. In
  // MD_HOLD the result is already in hand; only the memory wait holds E.
  assign md_stall = (in_idle & md_start_e) | (in_busy & ~md_done);

  // Launch is deferred while M is waiting so the op starts with the pipe moving.
  assign md_launch = in_idle & md_start_e & ~mem_wait;

  // ---------------------------------------------------------------------------
  // Stall / flush combination. Priority mem_wait > md_stall > lwstall > branch
  // falls out of the masking: a stalled E keeps the branch (and its flush) in
  // place until the first cycle E is free to advance.
  // ---------------------------------------------------------------------------
  logic stall_fd_raw, stall_e_raw, stall_m_raw;
  logic flush_d_raw, flush_e_raw, flush_m_raw, flush_w_raw;

  assign stall_e_raw  = mem_wait | md_stall;
  assign stall_fd_raw = stall_e_raw | lwstall;
  assign stall_m_raw  = mem_wait;

  assign flush_w_raw  = mem_wait;
  assign flush_m_raw  = md_stall & ~mem_wait;
  assign flush_e_raw  = (lwstall | pc_src_e) & ~stall_e_raw;
  assign flush_d_raw  = pc_src_e & ~stall_e_raw;

  // During reset the pipe is drained: nothing holds, every stage takes a
  // bubble, and no launch or forward escapes.
  always_comb begin
    forward_a_e = FORWARD_NONE;
    forward_b_e = FORWARD_NONE;
    md_go       = 1'b0;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b1;
    flush_e     = 1'b1;
    flush_m     = 1'b1;
    flush_w     = 1'b1;
    if (rst_n) begin
      forward_a_e = fwd_a_raw;
      forward_b_e = fwd_b_raw;
      md_go       = md_launch;
      stall_f     = stall_fd_raw;
      stall_d     = stall_fd_raw;
      stall_e     = stall_e_raw;
      stall_m     = stall_m_raw;
      flush_d     = flush_d_raw;
      flush_e     = flush_e_raw;
      flush_m     = flush_m_raw;
      flush_w     = flush_w_raw;
    end
  end

  // ---------------------------------------------------------------------------
  // Mul/div sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Any op in flight is abandoned; a still-held md_start_e relaunches.
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (md_launch) state_q <= ST_MD_BUSY;
        end
        ST_MD_BUSY: begin
          if (md_done) state_q <= mem_wait ? ST_MD_HOLD : ST_IDLE;
        end
        ST_MD_HOLD: begin
          if (!mem_wait) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign md_state_o = state_q;

  // ---------------------------------------------------------------------------
  // Performance counters (saturating, clear beats increment)
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_fd_raw && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_d_raw  && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed scenarios followed by a randomized run. Every cycle, all outputs are
// compared with a behavioural model that evaluates the hazard rules directly
// from the current inputs plus two facts about the mul/div op (launched and
// waiting for done / done already received). Directed scenarios add explicit
// checks against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_WB   = 2'b01;
  localparam logic [1:0] F_MEM  = 2'b10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic              reg_write_m, reg_write_w;
  logic [1:0]        result_src_e;
  logic              pc_src_e, md_start_e, md_done;
  logic              mem_req_m, mem_ready_m, perf_clr;

  logic [1:0]        forward_a_e, forward_b_e;
  logic              md_go;
  logic              stall_f, stall_d, stall_e, stall_m;
  logic              flush_d, flush_e, flush_m, flush_w;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic [1:0]        md_state_o;

  hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_e(result_src_e), .pc_src_e(pc_src_e), .md_start_e(md_start_e),
    .md_done(md_done), .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .perf_clr(perf_clr),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .md_go(md_go),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .md_state_o(md_state_o)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_launched;   // op launched, done not yet seen
  bit m_have_done;  // done seen while memory was waiting
  int m_scnt, m_fcnt;

  logic [1:0] e_fa, e_fb, e_state;
  logic e_go, e_sf, e_se, e_sm, e_fd, e_fe, e_fm, e_fw;

  function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] rs);
    if (rs == 0) return F_NONE;
    if (reg_write_m && rs == rd_m) return F_MEM;
    if (reg_write_w && rs == rd_w) return F_WB;
    return F_NONE;
  endfunction

  task automatic model_outputs();
    bit mw, lw, idle, mds;
    mw   = mem_req_m && !mem_ready_m;
    lw   = result_src_e[0] && (rd_e != 0) && (rs1_d == rd_e || rs2_d == rd_e);
    idle = !m_launched && !m_have_done;
    mds  = (idle && md_start_e) || (m_launched && !md_done);
    e_fa = ref_fwd(rs1_e);
    e_fb = ref_fwd(rs2_e);
    e_go = idle && md_start_e && !mw;
    e_se = mw || mds;
    e_sf = e_se || lw;
    e_sm = mw;
    e_fw = mw;
    e_fm = mds && !mw;
    e_fe = (lw || pc_src_e) && !e_se;
    e_fd = pc_src_e && !e_se;
    e_state = m_launched ? 2'd1 : (m_have_done ? 2'd2 : 2'd0);
    if (!rst_n) begin
      e_fa = F_NONE; e_fb = F_NONE; e_go = 1'b0;
      e_sf = 1'b0; e_se = 1'b0; e_sm = 1'b0;
      e_fd = 1'b1; e_fe = 1'b1; e_fm = 1'b1; e_fw = 1'b1;
    end
  endtask

  task automatic model_advance();
    bit mw;
    mw = mem_req_m && !mem_ready_m;
    if (!rst_n) begin
      m_launched = 0; m_have_done = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (e_go) begin
        m_launched = 1;
      end else if (m_launched && md_done) begin
        m_launched  = 0;
        m_have_done = mw;
      end else if (m_have_done && !mw) begin
        m_have_done = 0;
      end
      if (perf_clr) begin
        m_scnt = 0; m_fcnt = 0;
      end else begin
        if (e_sf && m_scnt < CMAX) m_scnt++;
        if (e_fd && m_fcnt < CMAX) m_fcnt++;
      end
    end
  endtask

  // Sampled copies of the outputs from the most recent cycle.
  logic [1:0] s_fa, s_state;
  logic s_go, s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_fm, s_fw;

  // One clock: inputs already set; check at negedge, advance model, take edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    model_outputs();
    s_fa = forward_a_e; s_state = md_state_o; s_go = md_go;
    s_sf = stall_f; s_sd = stall_d; s_se = stall_e; s_sm = stall_m;
    s_fd = flush_d; s_fe = flush_e; s_fm = flush_m; s_fw = flush_w;
    chk({tag, ".fwd_a"},   64'(forward_a_e), 64'(e_fa));
    chk({tag, ".fwd_b"},   64'(forward_b_e), 64'(e_fb));
    chk({tag, ".md_go"},   64'(md_go),       64'(e_go));
    chk({tag, ".stall_f"}, 64'(stall_f),     64'(e_sf));
    chk({tag, ".stall_d"}, 64'(stall_d),     64'(e_sf));
    chk({tag, ".stall_e"}, 64'(stall_e),     64'(e_se));
    chk({tag, ".stall_m"}, 64'(stall_m),     64'(e_sm));
    chk({tag, ".flush_d"}, 64'(flush_d),     64'(e_fd));
    chk({tag, ".flush_e"}, 64'(flush_e),     64'(e_fe));
    chk({tag, ".flush_m"}, 64'(flush_m),     64'(e_fm));
    chk({tag, ".flush_w"}, 64'(flush_w),     64'(e_fw));
    chk({tag, ".scnt"},    64'(stall_cnt),   64'(m_scnt));
    chk({tag, ".fcnt"},    64'(flush_cnt),   64'(m_fcnt));
    if (rst_n) chk({tag, ".state"}, 64'(md_state_o), 64'(e_state));
    model_advance();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic quiet();
    rs1_d = 5'd1; rs2_d = 5'd2; rs1_e = 5'd3; rs2_e = 5'd4; rd_e = 5'd9;
    rd_m = 5'd10; rd_w = 5'd11; reg_write_m = 0; reg_write_w = 0;
    result_src_e = 2'b00; pc_src_e = 0; md_start_e = 0; md_done = 0;
    mem_req_m = 0; mem_ready_m = 1; perf_clr = 0;
  endtask

  task automatic randomize_inputs(input int rst_pct);
    rs1_d = REG_AW'($urandom_range(0, 3)); rs2_d = REG_AW'($urandom_range(0, 3));
    rs1_e = REG_AW'($urandom_range(0, 3)); rs2_e = REG_AW'($urandom_range(0, 3));
    rd_e  = REG_AW'($urandom_range(0, 3)); rd_m  = REG_AW'($urandom_range(0, 3));
    rd_w  = REG_AW'($urandom_range(0, 3));
    reg_write_m  = 1'($urandom_range(0, 1));
    reg_write_w  = 1'($urandom_range(0, 1));
    result_src_e = 2'($urandom_range(0, 3));
    pc_src_e     = ($urandom_range(0, 99) < 25);
    md_start_e   = ($urandom_range(0, 99) < 35);
    md_done      = ($urandom_range(0, 99) < 25);
    mem_req_m    = 1'($urandom_range(0, 1));
    mem_ready_m  = 1'($urandom_range(0, 1));
    perf_clr     = ($urandom_range(0, 99) < 2);
    rst_n        = !($urandom_range(0, 99) < rst_pct);
  endtask

  int go_cnt, sm_cnt;

  initial begin
    m_launched = 0; m_have_done = 0; m_scnt = 0; m_fcnt = 0;

    // ---- reset with arbitrary inputs: outputs forced, counters zero ----
    for (int i = 0; i < 4; i++) begin
      randomize_inputs(0);
      rst_n = 0;
      cycle("reset");
      chk("reset.flush_w", 64'(s_fw), 64'(1));
      chk("reset.stall_f", 64'(s_sf), 64'(0));
    end
    quiet(); rst_n = 1;
    cycle("idle");

    // ---- forwarding ----
    rs1_e = 5; rd_m = 5; rd_w = 5; reg_write_m = 1; reg_write_w = 1;
    cycle("fwd_mem");
    chk("fwd_mem.const", 64'(s_fa), 64'(F_MEM));
    reg_write_m = 0;
    cycle("fwd_wb");
    chk("fwd_wb.const", 64'(s_fa), 64'(F_WB));
    rs1_e = 0; rd_m = 0; rd_w = 0; reg_write_m = 1;
    cycle("fwd_x0");
    chk("fwd_x0.const", 64'(s_fa), 64'(F_NONE));
    quiet();

    // ---- load-use ----
    result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
    cycle("lw");
    chk("lw.stall_f", 64'(s_sf), 64'(1));
    chk("lw.flush_e", 64'(s_fe), 64'(1));
    rd_e = 0; rs2_d = 0;
    cycle("lw_x0");
    chk("lw_x0.stall_f", 64'(s_sf), 64'(0));
    quiet();

    // ---- mul/div: done 4 cycles after go ----
    md_start_e = 1; go_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle("md_run");
      go_cnt += int'(s_go);
      chk("md_run.stall_e", 64'(s_se), 64'(1));
      chk("md_run.flush_m", 64'(s_fm), 64'(1));
    end
    md_done = 1;
    cycle("md_done");
    chk("md_done.stall_e", 64'(s_se), 64'(0));
    chk("md_run.go_once", 64'(go_cnt), 64'(1));
    quiet();
    cycle("md_after");

    // ---- mul/div done during a 3-cycle memory wait ----
    md_start_e = 1; go_cnt = 0; sm_cnt = 0;
    cycle("ov_go"); go_cnt += int'(s_go);
    cycle("ov_busy"); go_cnt += int'(s_go);
    md_done = 1; mem_req_m = 1; mem_ready_m = 0;
    cycle("ov_w0"); go_cnt += int'(s_go); sm_cnt += int'(s_sm && s_fw);
    md_done = 0;
    for (int i = 0; i < 2; i++) begin
      cycle("ov_w");
      go_cnt += int'(s_go); sm_cnt += int'(s_sm && s_fw);
      chk("ov.state_hold", 64'(s_state), 64'(2));
    end
    mem_ready_m = 1;
    cycle("ov_rel"); go_cnt += int'(s_go); sm_cnt += int'(s_sm && s_fw);
    chk("ov.go_once", 64'(go_cnt), 64'(1));
    chk("ov.mem_wait_cycles", 64'(sm_cnt), 64'(3));
    chk("ov.state_idle", 64'(md_state_o), 64'(0));
    quiet();

    // ---- branch during memory wait ----
    perf_clr = 1;
    cycle("br_clr");
    perf_clr = 0; pc_src_e = 1; mem_req_m = 1; mem_ready_m = 0;
    for (int i = 0; i < 2; i++) begin
      cycle("br_wait");
      chk("br_wait.flush_d", 64'(s_fd), 64'(0));
      chk("br_wait.flush_e", 64'(s_fe), 64'(0));
    end
    mem_ready_m = 1;
    cycle("br_go");
    chk("br_go.flush_d", 64'(s_fd), 64'(1));
    chk("br_go.flush_e", 64'(s_fe), 64'(1));
    chk("br_go.flush_cnt", 64'(flush_cnt), 64'(1));
    quiet();

    // ---- counter saturation and clear ----
    perf_clr = 1;
    cycle("cnt_clr0");
    perf_clr = 0; mem_req_m = 1; mem_ready_m = 0;
    for (int i = 0; i < 20; i++) cycle("cnt_stall");
    chk("cnt.sat", 64'(stall_cnt), 64'(15));
    perf_clr = 1;
    cycle("cnt_clr");
    chk("cnt.cleared", 64'(stall_cnt), 64'(0));
    quiet();

    // ---- reset during an op; held start relaunches ----
    md_start_e = 1;
    cycle("rst_go");
    cycle("rst_busy");
    rst_n = 0;
    cycle("rst_mid");
    rst_n = 1;
    cycle("rst_relaunch");
    chk("rst_relaunch.go", 64'(s_go), 64'(1));
    md_done = 1;
    cycle("rst_done");
    quiet();

    // ---- randomized run ----
    for (int i = 0; i < 1500; i++) begin
      randomize_inputs(1);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
